// File: rtl/serial_word_adder_pkg.sv
// Shared types and constants for the byte-serial word adder.
package serial_word_adder_pkg;

  // Width of the single arithmetic slice processed per cycle.
  localparam int BYTE_W = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_word_adder_bka8.sv
// 8-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
module BrentKungAdder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic       g10, p10, g32, p32, g54, p54, g76, p76;
  logic       g30, p30, g74, p74;
  logic [7:0] gp;
  logic [7:0] pp;
  logic [8:0] c;

  // Bit-level generate and propagate.
  assign g = a & b;
  assign p = a ^ b;

  // Up-sweep, level 1: pairs.
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g54 = g[5] | (p[5] & g[4]);
  assign p54 = p[5] & p[4];
  assign g76 = g[7] | (p[7] & g[6]);
  assign p76 = p[7] & p[6];

  // Up-sweep, level 2: nibbles.
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;
  assign g74 = g76 | (p76 & g54);
  assign p74 = p76 & p54;

  // Prefix group (i:0) for every bit, finishing with the down-sweep.
  assign gp[0] = g[0];
  assign pp[0] = p[0];
  assign gp[1] = g10;
  assign pp[1] = p10;
  assign gp[2] = g[2] | (p[2] & g10);
  assign pp[2] = p[2] & p10;
  assign gp[3] = g30;
  assign pp[3] = p30;
  assign gp[4] = g[4] | (p[4] & g30);
  assign pp[4] = p[4] & p30;
  assign gp[5] = g54 | (p54 & g30);
  assign pp[5] = p54 & p30;
  assign gp[6] = g[6] | (p[6] & gp[5]);
  assign pp[6] = p[6] & pp[5];
  assign gp[7] = g74 | (p74 & g30);
  assign pp[7] = p74 & p30;

  // Fold the external carry-in into every prefix carry.
  assign c[0]   = cin;
  assign c[8:1] = gp | (pp & {8{cin}});

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/serial_word_adder.sv
// Word-wide add/subtract performed one byte per cycle through a single
// 8-bit prefix adder, with a ready/valid handshake on both sides.
module serial_word_adder
  import serial_word_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t          state;
  state_t          state_nx;
  logic            accept;
  logic            last;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] s_byte;
  logic            c_byte;

  assign a_byte = op_a[idx*BYTE_W +: BYTE_W];
  assign b_byte = op_b[idx*BYTE_W +: BYTE_W];
  assign last   = (state == ADD) && (idx == LAST_IDX);

  BrentKungAdder8 u_adder (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .sum  (s_byte),
    .cout (c_byte)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and handshake outputs; a request is taken in IDLE or
  // in DONE on the same edge the old result retires.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = ADD;
        end
      end
      ADD: begin
        if (idx == LAST_IDX) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept   = 1'b1;
            state_nx = ADD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, byte-serial accumulation and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      idx   <= '0;
    end else if (state == ADD) begin
      sum[idx*BYTE_W +: BYTE_W] <= s_byte;
      carry <= c_byte;
      if (last) begin
        cout <= c_byte;
        ovf  <= (op_a[W-1] == op_b[W-1]) && (s_byte[BYTE_W-1] != op_a[W-1]);
        idx  <= '0;
      end else begin
        idx  <= idx + IW'(1);
      end
    end
  end

endmodule

// File: doc/serial_word_adder.md
SERIAL_WORD_ADDER -- requirements
Module: serial_word_adder

Interface
REQ-001 Parameter NBYTES, default 4, operand width in bytes (W = 8*NBYTES), legal range 2..8.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in; ignored when sub=1.
REQ-009 sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  W  result word.
REQ-013 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 ovf  output  1  signed two's-complement overflow.

Function
REQ-015 The block SHALL compute a W-bit add one byte per cycle through a single 8-bit prefix adder, chaining that adder's carry-out into its carry-in through a carry register.
REQ-016 FSM states SHALL be IDLE, ADD, DONE; reset state is IDLE.
REQ-017 IDLE: in_ready=1; on in_valid, latch a, b (b inverted when sub=1), and carry = sub ? 1 : cin; clear byte index; go to ADD.
REQ-018 ADD: each cycle adds byte[idx] of latched A and B with the carry register, writes the 8-bit sum into byte[idx] of the result register, updates the carry register, increments idx.
REQ-019 ADD SHALL last exactly NBYTES cycles; on the cycle processing idx=NBYTES-1, go to DONE.
REQ-020 ovf SHALL be computed in the last ADD cycle as (A[W-1] == B'[W-1]) and (sum[W-1] != A[W-1]), with B' the possibly inverted operand.
REQ-021 DONE: out_valid=1; sum, cout, ovf stable until handshake; on out_ready go to IDLE, or directly to ADD when in_valid is also 1.
REQ-022 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready); in ADD in_ready=0 and a, b, cin, sub are ignored.
REQ-023 Latency: request accepted on edge N, out_valid high from edge N+NBYTES; throughput one result per NBYTES+1 cycles under continuous valid/ready.
REQ-024 Simultaneous out_ready and in_valid in DONE SHALL retire the old result and latch the new operands on the same edge with no bubble cycle.
REQ-025 out_valid SHALL be held indefinitely while out_ready=0; no result is ever dropped or overwritten.
REQ-026 Byte index counter SHALL be ceil(log2(NBYTES)) bits and never exceed NBYTES-1.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, carry register=0, idx=0, operand registers=0.
REQ-028 Reset asserted in ADD or DONE SHALL abort the operation; no partial result SHALL appear after release.
REQ-029 After rst_n deasserts, in_ready=1 on the first clock.

Structure
REQ-030 Shared package SHALL hold the FSM state enumeration (IDLE, ADD, DONE) and the byte width constant 8.
REQ-031 One sub-module SHALL be instantiated: BrentKungAdder8, the team's existing 8-bit prefix adder, unchanged, as the only arithmetic in the datapath.

Verification
REQ-032 NBYTES=4, a=0x000000FF, b=0x00000001, cin=0, sub=0 -> sum=0x00000100, cout=0, ovf=0, out_valid 4 cycles after accept.
REQ-033 a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0 (full carry ripple across all bytes).
REQ-034 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1; a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-035 Back-to-back requests with out_ready=1: second request accepted in DONE cycle of first, results every 5 cycles, no bubble; out_ready held 0 for 10 cycles -> sum/cout/ovf stable, in_ready=0.
REQ-036 Assert rst_n low during ADD idx=2 -> all outputs 0 immediately, IDLE after release, next request a=1,b=2 -> sum=3.
REQ-037 Randomised 1000 requests, random sub/cin/ready stalls, compared against W-bit reference model for sum, cout, ovf.
